dmem_byte_bridge: RTL and testbench
===================================

// Module: dmem_byte_bridge
// PURPOSE
//   Data-memory bridge between mips_core's word-wide load/store port and a byte-wide handshaked data SRAM.
//   Splits one 32-bit access into four sequential byte transfers and stalls the core's PC update until done.
//   Sits directly downstream of the core's mem_addr/mem_data_in/mem_write_en; feeds its mem_data_out[0:3].
//   Byte order is big-endian: lane k <-> byte address base+k; word = {lane0,lane1,lane2,lane3}.
// PARAMETERS
//   ADDR_W   16  width of the SRAM byte address; core_addr[ADDR_W-1:0] used, upper bits ignored
// PORTS
//   clk          in   1      single clock, all state on rising edge
//   rst_b        in   1      reset; one clock; reset is asynchronous and active-high
//   core_addr    in   32     byte address of access (core ALU result)
//   core_wdata   in   8x4    store data lanes [0:3]
//   core_we      in   1      store request (level, held by core while stalled)
//   core_re      in   1      load request (level, held by core while stalled)
//   core_rdata   out  8x4    load data lanes [0:3], registered
//   core_stall   out  1      1 = core must not advance inst_addr this cycle
//   mem_req      out  1      byte transfer request to SRAM
//   mem_we       out  1      1 = byte write, 0 = byte read; valid while mem_req
//   mem_addr     out  ADDR_W byte address; valid while mem_req
//   mem_wbyte    out  8      write byte; valid while mem_req & mem_we
//   mem_rbyte    in   8      read byte; valid in cycle mem_ack=1
//   mem_ack      in   1      transfer done this cycle; ignored when mem_req=0
//   misalign_err out  1      one-cycle pulse, see CONFIGURATION
// BEHAVIOUR
//   Reset: state=IDLE, idx=0, core_rdata all 0, latched addr/data/we 0; all outputs 0. Async reset mid-transfer
//     aborts at once (mem_req drops with reset, not at next edge); partially written bytes stay written.
//   FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: if core_re|core_we: latch base=core_addr[ADDR_W-1:0], wdata lanes, we=core_we; idx<=0; go BUSY.
//     core_we and core_re both high: treated as store. Neither high: stay IDLE.
//   BUSY: mem_req=1, mem_we=we, mem_addr=base+idx (mod 2^ADDR_W, wraps past max), mem_wbyte=lane[idx].
//     On mem_ack: for loads core_rdata[idx]<=mem_rbyte; if idx==3 go DONE else idx<=idx+1.
//     mem_req stays high across bytes; address/data change only on the edge after an ack. No ack: hold forever.
//   DONE: mem_req=0; one cycle; go IDLE. Requests are not sampled in DONE.
//   core_stall = (IDLE & (core_re|core_we)) | BUSY. Low in DONE so the core commits and advances exactly then.
//   core_rdata updated only by loads; holds last load value through stores and idle cycles.
//   Latency with ack every cycle: stall high 5 cycles (1 IDLE + 4 BUSY), low in DONE = cycle 6.
//   Load data in core_rdata is valid in DONE (same cycle core writes its regfile).
// CONFIGURATION
//   DMEM_ALIGN_CHECK_EN defined: in IDLE, request with core_addr[1:0]!=0 skips BUSY, goes straight to DONE,
//     misalign_err=1 during that DONE cycle, no mem_req, core_rdata set to 0 for loads. Stall = 1 cycle.
//   DMEM_ALIGN_CHECK_EN undefined: misalign_err tied 0; unaligned base accessed as base..base+3 bytewise.
// TESTING
//   1 Reset: assert rst_b mid-BUSY -> mem_req, core_stall, core_rdata immediately 0; state IDLE after release.
//   2 Store core_addr=0x100, wdata={AA,BB,CC,DD}, ack every cycle -> writes 0x100=AA..0x103=DD, stall 5 cycles.
//   3 Load 0x100 with ack after 2 wait cycles per byte -> core_rdata={AA,BB,CC,DD} in DONE, stall 13 cycles.
//   4 Load base=2^ADDR_W-2 -> mem_addr sequence FFFE,FFFF,0000,0001 (ADDR_W=16).
//   5 core_re=core_we=1 at 0x20 -> four byte writes, core_rdata unchanged from prior load.
//   6 With DMEM_ALIGN_CHECK_EN, load 0x102 -> no mem_req, misalign_err pulse 1 cycle, rdata 0; without: 4 reads 0x102..0x105.

Source files
------------

// File: rtl/dmem_byte_bridge.sv
// Word-to-byte data-memory bridge: splits a 32-bit core load/store into four big-endian byte transfers.
// Optional `DMEM_ALIGN_CHECK_EN: unaligned requests are rejected with a one-cycle misalign_err pulse.
module dmem_byte_bridge #(
  parameter int ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [31:0]          core_addr,
  input  logic [0:3][7:0]      core_wdata,
  input  logic                 core_we,
  input  logic                 core_re,
  output logic [0:3][7:0]      core_rdata,
  output logic                 core_stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [7:0]           mem_wbyte,
  input  logic [7:0]           mem_rbyte,
  input  logic                 mem_ack,
  output logic                 misalign_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        idx;
  logic [ADDR_W-1:0] base;
  logic [0:3][7:0]   wdata_q;
  logic              we_q;
  logic              core_req;
  logic              busy;
  logic              misalign;
  logic              unused_addr;

  assign core_req    = core_re | core_we;
  assign busy        = (state == S_BUSY);
  assign unused_addr = ^core_addr[31:ADDR_W];

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;

  assign misalign = (core_addr[1:0] != 2'b00);

  // Registered so the pulse lands exactly on the DONE cycle the rejected request jumps to.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) err_q <= 1'b0;
    else       err_q <= (state == S_IDLE) && core_req && misalign;
  end

  assign misalign_err = err_q;
`else
  assign misalign     = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state      <= S_IDLE;
      idx        <= 2'd0;
      base       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      core_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (core_req) begin
            base    <= core_addr[ADDR_W-1:0];
            wdata_q <= core_wdata;
            we_q    <= core_we;
            idx     <= 2'd0;
            if (misalign) begin
              state <= S_DONE;
              if (!core_we) core_rdata <= '0;
            end else begin
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            if (!we_q) core_rdata[idx] <= mem_rbyte;
            if (idx == 2'd3) state <= S_DONE;
            else             idx   <= idx + 2'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stall is gated by reset so it drops together with the aborted transfer.
  assign core_stall = !rst_b && (((state == S_IDLE) && core_req) || busy);
  assign mem_req    = busy;
  assign mem_we     = busy && we_q;
  assign mem_addr   = busy ? base + ADDR_W'(idx) : '0;
  assign mem_wbyte  = (busy && we_q) ? wdata_q[idx] : 8'h00;

endmodule

// File: tb/tb_dmem_byte_bridge.sv
// Scoreboard bench for dmem_byte_bridge: a byte-array reference model predicts each word access,
// a randomly stalling SRAM model logs byte transfers, and a monitor compares at every completion.
module tb_dmem_byte_bridge;
  localparam int ADDR_W = 16;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_b = 1'b1;
  logic [31:0]       core_addr = '0;
  logic [0:3][7:0]   core_wdata = '0;
  logic              core_we = 1'b0;
  logic              core_re = 1'b0;
  logic [0:3][7:0]   core_rdata;
  logic              core_stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wbyte;
  logic [7:0]        mem_rbyte = '0;
  logic              mem_ack = 1'b0;
  logic              misalign_err;

  dmem_byte_bridge #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_b(rst_b), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_we(core_we), .core_re(core_re), .core_rdata(core_rdata), .core_stall(core_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wbyte(mem_wbyte),
    .mem_rbyte(mem_rbyte), .mem_ack(mem_ack), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mis;
    logic [31:0] rdata;
    int          nops;
    int          stall_exp;
  } txn_t;

  txn_t        exp_q[$];
  logic [24:0] exp_ops[$];
  logic [24:0] obs_ops[$];
  logic [7:0]  sram    [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [31:0] last_load = '0;
  int n_cmp = 0, n_err = 0;
  int wait_mode = 0;
  int completions = 0;
  int stall_cnt = 0;
  bit prev_stall = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  function automatic int pick_wait();
    return (wait_mode >= 0) ? wait_mode : int'($urandom_range(0, 2));
  endfunction

  // SRAM model: responds after a per-byte wait, logs every acknowledged transfer.
  int cnt = 0, cur_wait = 0;
  always @(posedge clk) begin
    #2;
    if (rst_b || !mem_req) begin
      mem_ack  = 1'b0;
      cnt      = 0;
      cur_wait = pick_wait();
    end else if (cnt >= cur_wait) begin
      mem_ack   = 1'b1;
      mem_rbyte = sram[mem_addr];
      obs_ops.push_back({mem_we, mem_addr, mem_we ? mem_wbyte : 8'h00});
      if (mem_we) sram[mem_addr] = mem_wbyte;
      cnt      = 0;
      cur_wait = pick_wait();
    end else begin
      mem_ack   = 1'b0;
      mem_rbyte = 8'($urandom);
      cnt++;
    end
  end

  // Monitor: a falling core_stall marks the commit cycle of one access.
  txn_t        t_m;
  logic [24:0] e_m, o_m;
  always @(negedge clk) begin
    if (rst_b) begin
      prev_stall = 1'b0;
      stall_cnt  = 0;
    end else begin
      if (core_stall) begin
        stall_cnt++;
      end else if (prev_stall) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          t_m = exp_q.pop_front();
          check("rdata", core_rdata, t_m.rdata);
          check("misalign_err", misalign_err, t_m.mis);
          if (t_m.stall_exp >= 0) check("stall_cycles", stall_cnt, t_m.stall_exp);
          check("byte_count", obs_ops.size(), t_m.nops);
          for (int i = 0; i < t_m.nops; i++) begin
            e_m = exp_ops.pop_front();
            if (obs_ops.size() > 0) begin
              o_m = obs_ops.pop_front();
              check("byte_op", o_m, e_m);
            end
          end
          obs_ops.delete();
        end
        stall_cnt = 0;
        completions++;
      end else if (misalign_err) begin
        check("misalign_spurious", misalign_err, 0);
      end
      prev_stall = core_stall;
    end
  end

  // Reference model of one word access plus the driver that holds the request until commit.
  task automatic issue(input logic [31:0] addr, input logic we, input logic re, input logic [31:0] wd);
    txn_t t;
    logic [15:0] a;
    int c0;
    t.mis = ALIGN && (addr[1:0] != 2'b00);
    if (t.mis) begin
      t.nops = 0;
      if (!we) last_load = '0;
    end else begin
      t.nops = 4;
      for (int k = 0; k < 4; k++) begin
        a = addr[15:0] + 16'(k);
        if (we) begin
          ref_mem[a] = wd[31 - 8*k -: 8];
          exp_ops.push_back({1'b1, a, wd[31 - 8*k -: 8]});
        end else begin
          last_load[31 - 8*k -: 8] = ref_mem[a];
          exp_ops.push_back({1'b0, a, 8'h00});
        end
      end
    end
    t.rdata     = last_load;
    t.stall_exp = t.mis ? 1 : ((wait_mode >= 0) ? 1 + 4 * (wait_mode + 1) : -1);
    exp_q.push_back(t);
    core_addr  = addr;
    core_wdata = wd;
    core_we    = we;
    core_re    = re;
    c0 = completions;
    for (int i = 0; i < 300 && completions == c0; i++) begin
      @(posedge clk); #1;
    end
    if (completions == c0) begin
      check("access_timeout", 0, 1);
      summary();
    end
    core_we    = 1'b0;
    core_re    = 1'b0;
    core_addr  = $urandom;
    core_wdata = $urandom;
  endtask

  logic [31:0] r, w;
  int sel;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      sram[i]    = 8'($urandom);
      ref_mem[i] = sram[i];
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", core_rdata, 32'h0);
    check("reset_mem_req", mem_req, 1'b0);
    check("reset_stall", core_stall, 1'b0);
    rst_b = 1'b0;
    @(posedge clk); #1;
    check("idle_stall", core_stall, 1'b0);

    wait_mode = 0;
    issue(32'h0000_0100, 1'b1, 1'b0, 32'hAABB_CCDD);
    wait_mode = 2;
    issue(32'h0000_0100, 1'b0, 1'b1, $urandom);
    check("load_word_0x100", last_load, 32'hAABB_CCDD);

    // Abort a load mid-transfer with an asynchronous reset.
    wait_mode = 50;
    core_addr = 32'h0000_0200;
    core_re   = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    rst_b = 1'b1;
    #1;
    check("abort_mem_req", mem_req, 1'b0);
    check("abort_stall", core_stall, 1'b0);
    check("abort_rdata", core_rdata, 32'h0);
    core_re = 1'b0;
    last_load = '0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_b = 1'b0;
    obs_ops.delete();
    @(posedge clk); #1;
    check("post_reset_mem_req", mem_req, 1'b0);

    wait_mode = 0;
    issue(32'h1234_FFFE, 1'b0, 1'b1, $urandom);
    issue(32'h0000_0040, 1'b0, 1'b1, $urandom);
    issue(32'h0000_0020, 1'b1, 1'b1, $urandom);
    issue(32'h0000_0102, 1'b0, 1'b1, $urandom);
    issue(32'h0000_0103, 1'b1, 1'b0, $urandom);

    wait_mode = -1;
    for (int n = 0; n < 60; n++) begin
      r = $urandom;
      w = $urandom;
      case ($urandom_range(0, 2))
        0:       r = {r[31:16], 16'h0100 + 16'($urandom_range(0, 31))};
        1:       r = {r[31:16], 16'hFFF0 + 16'($urandom_range(0, 15))};
        default: r = {r[31:2], 2'b00};
      endcase
      sel = $urandom_range(0, 2);
      issue(r, sel != 1, sel != 0, w);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    check("pending_txns", exp_q.size(), 0);
    summary();
  end

endmodule
